// File: rtl/classifier_arbiter.sv
// -----------------------------------------------------------------------------
// classifier_arbiter
//   Round-robin arbiter that shares one packet classifier between NUM_PORTS
//   requesters. Issues a single-cycle start pulse, waits for the classifier
//   to go busy and then idle again, and returns the matched rule range with
//   the requester's port id and the measured latency.
//   Optional statistics: define CLASSIFIER_ARB_STATS_EN.
//   Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module classifier_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS),
  parameter int LAT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [NUM_PORTS*104-1:0]   req_packet,
  output logic [NUM_PORTS-1:0]       req_ready,
  output logic                       cls_input_is_valid,
  output logic [103:0]               cls_packet,
  input  logic                       cls_ready_to_process,
  input  logic [103:0]               cls_first,
  input  logic [103:0]               cls_last,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [PORT_W-1:0]          resp_port,
  output logic [103:0]               resp_first,
  output logic [103:0]               resp_last,
  output logic [LAT_W-1:0]           resp_cycles
`ifdef CLASSIFIER_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]    stat_grants,
  output logic [LAT_W-1:0]           stat_max_cycles,
  input  logic                       stat_clear
`endif
);

  localparam int PKT_W = 104;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state;
  logic [PORT_W-1:0]    rr_ptr;
  logic                 seen_busy;
  logic [LAT_W-1:0]     cnt;
  logic [LAT_W-1:0]     cnt_inc;
  logic                 grant_found;
  logic [PORT_W-1:0]    grant_idx;
  logic [PORT_W-1:0]    cand;
  logic [PORT_W-1:0]    next_ptr;
  logic [PKT_W-1:0]     sel_packet;
  logic                 grant;
  logic                 capture;

  // Round-robin search: first valid port starting at rr_ptr, wrapping modulo NUM_PORTS
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PORT_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Packet of the granted port
  always_comb begin
    sel_packet = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_idx == PORT_W'(p)) begin
        sel_packet = req_packet[p*PKT_W +: PKT_W];
      end
    end
  end

  // Grant only from IDLE with an idle classifier; reset forces the accept low
  always_comb begin
    req_ready = '0;
    if (!reset && grant) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign grant    = (state == IDLE) && cls_ready_to_process && grant_found;
  assign capture  = (state == WAIT) && seen_busy && cls_ready_to_process;
  assign next_ptr = (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  assign cnt_inc  = (cnt == {LAT_W{1'b1}}) ? cnt : cnt + 1'b1;

  // Request sequencer: grant, start pulse, wait for busy-then-idle, hold response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      seen_busy          <= 1'b0;
      cnt                <= '0;
      cls_input_is_valid <= 1'b0;
      cls_packet         <= '0;
      resp_valid         <= 1'b0;
      resp_port          <= '0;
      resp_first         <= '0;
      resp_last          <= '0;
      resp_cycles        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            cls_packet         <= sel_packet;
            resp_port          <= grant_idx;
            rr_ptr             <= next_ptr;
            cls_input_is_valid <= 1'b1;
            cnt                <= '0;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          cls_input_is_valid <= 1'b0;
          seen_busy          <= 1'b0;
          cnt                <= cnt_inc;
          state              <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_inc;
          // Ready seen before the busy phase is the classifier's drop latency
          if (!cls_ready_to_process) begin
            seen_busy <= 1'b1;
          end
          if (capture) begin
            resp_first  <= cls_first;
            resp_last   <= cls_last;
            resp_cycles <= cnt;
            resp_valid  <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLASSIFIER_ARB_STATS_EN
  // Per-port grant counters and worst-case latency; clear has priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants     <= '0;
      stat_max_cycles <= '0;
    end else if (stat_clear) begin
      stat_grants     <= '0;
      stat_max_cycles <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant && (grant_idx == PORT_W'(p))) begin
          stat_grants[p*32 +: 32] <= stat_grants[p*32 +: 32] + 32'd1;
        end
      end
      if (capture && (cnt > stat_max_cycles)) begin
        stat_max_cycles <= cnt;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_classifier_arbiter.sv
// -----------------------------------------------------------------------------
// tb_classifier_arbiter
//   Self-checking bench: behavioural classifier model plus a round-robin /
//   latency reference computed from plain arithmetic.
// -----------------------------------------------------------------------------
`default_nettype none

module tb_classifier_arbiter;

  localparam int NP   = 4;
  localparam int LATW = 4;
  localparam int SAT  = (1 << LATW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   req_valid;
  logic [103:0]    pkts [NP];
  logic [NP*104-1:0] req_packet;
  logic [NP-1:0]   req_ready;
  logic            cls_input_is_valid;
  logic [103:0]    cls_packet;
  logic            cls_ready;
  logic [103:0]    m_first, m_last;
  logic            resp_valid;
  logic            resp_ready;
  logic [1:0]      resp_port;
  logic [103:0]    resp_first, resp_last;
  logic [LATW-1:0] resp_cycles;
  logic            stat_clear;
`ifdef CLASSIFIER_ARB_STATS_EN
  logic [NP*32-1:0] stat_grants;
  logic [LATW-1:0]  stat_max_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int exp_ptr = 0;
  int exp_max = 0;
  int exp_grants [NP];

  // classifier model controls
  logic model_ready;
  int   busy_left;
  int   busy_len = 1;
  logic hold_busy = 1'b0;

  assign req_packet = {pkts[3], pkts[2], pkts[1], pkts[0]};
  assign cls_ready  = model_ready & ~hold_busy;

  always #5 clk = ~clk;

  classifier_arbiter #(.NUM_PORTS(NP), .PORT_W(2), .LAT_W(LATW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_packet(req_packet), .req_ready(req_ready),
    .cls_input_is_valid(cls_input_is_valid), .cls_packet(cls_packet),
    .cls_ready_to_process(cls_ready), .cls_first(m_first), .cls_last(m_last),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_port(resp_port),
    .resp_first(resp_first), .resp_last(resp_last), .resp_cycles(resp_cycles)
`ifdef CLASSIFIER_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_max_cycles(stat_max_cycles), .stat_clear(stat_clear)
`endif
  );

  function automatic logic [103:0] rand104();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[103:0];
  endfunction

  // Classifier: busy for busy_len cycles starting the cycle after the start pulse
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_ready <= 1'b1;
      busy_left   <= 0;
      m_first     <= '0;
      m_last      <= '0;
    end else if (cls_input_is_valid) begin
      model_ready <= 1'b0;
      busy_left   <= busy_len - 1;
      m_first     <= rand104();
      m_last      <= rand104();
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end else begin
      model_ready <= 1'b1;
    end
  end

  function automatic int rr_pick(input int ptr, input logic [NP-1:0] mask);
    for (int i = 0; i < NP; i++) begin
      int p = (ptr + i) % NP;
      if (mask[p]) return p;
    end
    return -1;
  endfunction

  task automatic randomize_packets();
    for (int p = 0; p < NP; p++) pkts[p] = rand104();
  endtask

  task automatic clear_model_stats();
    exp_max = 0;
    for (int p = 0; p < NP; p++) exp_grants[p] = 0;
  endtask

  // One complete request: grant, issue, wait, response with 'hold' cycles of backpressure
  task automatic transact(input logic [NP-1:0] mask, input int busy, input int hold);
    int g, n, exp_cyc;
    logic [NP-1:0] exp_rdy;
    logic bad;
    req_valid = mask;
    busy_len  = busy;
    #1;
    g = rr_pick(exp_ptr, mask);
    exp_rdy = NP'(1) << g;
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++; $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
    end
    @(posedge clk); #1;
    exp_ptr = (g + 1) % NP;
    exp_grants[g]++;
    checks++;
    if (cls_input_is_valid !== 1'b1 || cls_packet !== pkts[g] || req_ready !== '0) begin
      errors++; $display("FAIL issue: valid=%b pkt=%h ready=%b expected 1 %h 0000",
                         cls_input_is_valid, cls_packet, req_ready, pkts[g]);
    end
    @(posedge clk); #1;
    n = 0; bad = 1'b0;
    while (resp_valid !== 1'b1 && n < 200) begin
      if (req_ready !== '0 || cls_input_is_valid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200 || bad) begin
      errors++; $display("FAIL wait: timeout=%0d stray_activity=%0d expected 0 0", n >= 200, bad);
      return;
    end
    exp_cyc = (busy + 1 > SAT) ? SAT : busy + 1;
    if (exp_cyc > exp_max) exp_max = exp_cyc;
    checks++;
    if (resp_port !== 2'(g) || resp_first !== m_first || resp_last !== m_last ||
        resp_cycles !== LATW'(exp_cyc)) begin
      errors++; $display("FAIL resp: port=%0d cycles=%0d first_ok=%0d last_ok=%0d expected port=%0d cycles=%0d",
                         resp_port, resp_cycles, resp_first === m_first, resp_last === m_last, g, exp_cyc);
    end
    bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_port !== 2'(g) || resp_first !== m_first ||
          resp_last !== m_last || resp_cycles !== LATW'(exp_cyc) ||
          req_ready !== '0 || cls_input_is_valid !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) begin
      checks++;
      if (bad) begin
        errors++; $display("FAIL backpressure: unstable_or_stray=%0d expected 0", bad);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = '0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL handshake: resp_valid=%b expected 0", resp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; resp_ready = 1'b0; stat_clear = 1'b0;
    randomize_packets();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== '0 || cls_input_is_valid !== 0 || cls_packet !== '0 || resp_valid !== 0 ||
        resp_port !== '0 || resp_first !== '0 || resp_last !== '0 || resp_cycles !== '0) begin
      errors++; $display("FAIL reset_outputs: rdy=%b iv=%b rv=%b port=%0d cyc=%0d expected all 0",
                         req_ready, cls_input_is_valid, resp_valid, resp_port, resp_cycles);
    end
`ifdef CLASSIFIER_ARB_STATS_EN
    checks++;
    if (stat_grants !== '0 || stat_max_cycles !== '0) begin
      errors++; $display("FAIL reset_stats: grants=%h max=%0d expected 0 0", stat_grants, stat_max_cycles);
    end
`endif
    req_valid = '0;
    reset = 1'b0;
    exp_ptr = 0;
    clear_model_stats();
  endtask

  task automatic test_single();
    randomize_packets();
    pkts[0] = {32'h0A000001, 32'h0A000002, 16'd80, 16'd443, 8'd6};
    transact(4'b0001, 10, 0);
  endtask

  task automatic test_busy_classifier();
    hold_busy = 1'b1;
    req_valid = 4'b0100;
    randomize_packets();
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (req_ready !== '0) begin
        errors++; $display("FAIL busy_no_grant: req_ready=%b expected 0000", req_ready);
      end
    end
    hold_busy = 1'b0;
    transact(4'b0100, 3, 0);
  endtask

  task automatic test_backpressure();
    randomize_packets();
    transact(4'b0100, 5, 20);
    randomize_packets();
    transact(4'b0100, 2, 0);
  endtask

  task automatic test_reset_mid_wait();
    randomize_packets();
    req_valid = 4'b0100;
    busy_len  = 20;
    @(posedge clk); #1;
    exp_ptr = 3;
    repeat (3) begin @(posedge clk); #1; end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0 || cls_input_is_valid !== 0 || cls_packet !== '0 || resp_valid !== 0 ||
        resp_port !== '0 || resp_cycles !== '0 || resp_first !== '0 || resp_last !== '0) begin
      errors++; $display("FAIL async_reset: rdy=%b iv=%b pkt=%h rv=%b expected all 0",
                         req_ready, cls_input_is_valid, cls_packet, resp_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ptr = 0;
    clear_model_stats();
    randomize_packets();
    transact(4'b1010, 3, 0);
  endtask

  task automatic test_round_robin();
    reset = 1'b1; #2; reset = 1'b0;
    exp_ptr = 0;
    clear_model_stats();
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      randomize_packets();
      transact(4'b1111, 2 + k, 0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      randomize_packets();
      transact(NP'($urandom_range(1, 15)), $urandom_range(1, 20), $urandom_range(0, 3));
    end
  endtask

  task automatic test_saturation();
    randomize_packets();
    transact(4'b0001, 40, 0);
`ifdef CLASSIFIER_ARB_STATS_EN
    checks++;
    if (stat_max_cycles !== LATW'(exp_max)) begin
      errors++; $display("FAIL stat_max: got %0d expected %0d", stat_max_cycles, exp_max);
    end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (stat_grants[p*32 +: 32] !== 32'(exp_grants[p])) begin
        errors++; $display("FAIL stat_grants%0d: got %0d expected %0d", p, stat_grants[p*32 +: 32], exp_grants[p]);
      end
    end
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    checks++;
    if (stat_max_cycles !== '0 || stat_grants !== '0) begin
      errors++; $display("FAIL stat_clear: max=%0d grants=%h expected 0 0", stat_max_cycles, stat_grants);
    end
`endif
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_single();
    test_busy_classifier();
    test_backpressure();
    test_reset_mid_wait();
    test_round_robin();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/classifier_arbiter.md
Name: classifier_arbiter

Overview:
- Shares one `classifier` instance between NUM_PORTS packet requesters using round-robin arbitration.
- Per request: accepts the 5-tuple, issues the classifier's single-cycle `input_is_valid` pulse, and waits for `ready_to_process` to fall and then rise again.
- On completion, captures the matched rule range and returns it with the requester's port id and the measured classification latency.
- Sits between the ingress port queues and the classifier.

Parameters:
- NUM_PORTS, 4: number of requesters; must be at least 2.
- PORT_W, $clog2(NUM_PORTS): width of the port id.
- LAT_W, 16: width of the latency counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_packet  in  NUM_PORTS*104  per-port packet. Port p occupies bits [p*104 +: 104], packed as {src_ip[32], dst_ip[32], src_port[16], dst_port[16], protocol[8]}.
- req_ready  out  NUM_PORTS  per-port accept; one-hot or zero.
- cls_input_is_valid  out  1  start pulse to the classifier.
- cls_packet  out  104  packet to the classifier, same packing as req_packet.
- cls_ready_to_process  in  1  classifier idle flag.
- cls_first  in  104  classifier first_* fields, same packing.
- cls_last  in  104  classifier last_* fields, same packing.
- resp_valid  out  1  result valid.
- resp_ready  in  1  result consumer ready.
- resp_port  out  PORT_W  id of the requester being answered.
- resp_first  out  104  captured rule start.
- resp_last  out  104  captured rule end.
- resp_cycles  out  LAT_W  cycles from the ISSUE cycle to the capture cycle, saturating.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (asynchronous, any state):
  - State goes to IDLE; rr_ptr = 0.
  - All outputs 0: req_ready, cls_input_is_valid, cls_packet, resp_valid, resp_port, resp_first, resp_last, resp_cycles.
  - The classifier shares `reset`; a reset mid-operation abandons the in-flight request with no response.
- IDLE:
  - If cls_ready_to_process=1 and any req_valid is set, grant the first set port searching rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
  - req_ready[grant] is combinational in this cycle; the transfer completes at the clock edge.
  - Latch the packet into cls_packet, the port into resp_port, and set rr_ptr = grant+1 (wraps NUM_PORTS-1 to 0). Next state ISSUE.
  - If cls_ready_to_process=0, no grant; req_ready stays all zero.
- ISSUE: cls_input_is_valid=1 for exactly this one cycle; clear seen_busy; latency counter = 0. Next state WAIT.
- WAIT:
  - Counter increments every cycle, saturating at 2^LAT_W-1.
  - When cls_ready_to_process=0, set seen_busy.
  - When seen_busy=1 and cls_ready_to_process=1: capture cls_first into resp_first, cls_last into resp_last, counter into resp_cycles. Next state RESP.
  - A high ready before the busy phase has been observed is ignored; this covers the classifier's one-cycle drop latency.
- RESP:
  - resp_valid=1; resp_port, resp_first, resp_last and resp_cycles are held stable.
  - On resp_valid && resp_ready, go to IDLE. resp_valid is 0 in the following cycle.
- No new grant while a request is outstanding; strictly one request in flight.
- Requests that are not granted are not dropped; requesters hold req_valid and req_packet until req_ready.
- A req_valid that drops while not granted has no effect.
- Minimum turnaround is 4 cycles plus classifier busy time: IDLE(grant) → ISSUE → WAIT(at least 2) → RESP.
- A grant from IDLE is possible in the cycle after the RESP handshake.

Optional Feature:
- Macro: CLASSIFIER_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants (NUM_PORTS*32): per-port grant counters, incremented on each accepted request and wrapping at 2^32.
  - Adds output stat_max_cycles (LAT_W): largest resp_cycles seen.
  - Adds input stat_clear (1): synchronous clear of both statistics; if stat_clear coincides with a grant, the clear wins.
  - Both statistics are reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Single request: req_valid=0001, packet {0x0A000001, 0x0A000002, 80, 443, 6}. Classifier model busy 10 cycles, returns first=P, last=Q. Expect:
   - req_ready=0001 for one cycle, then one cls_input_is_valid pulse carrying the packet;
   - resp_valid with resp_port=0, resp_first=P, resp_last=Q, resp_cycles=11.
2. Round-robin fairness: req_valid=1111 held continuously, resp_ready=1 → grant order 0,1,2,3,0,1. Never two req_ready bits in the same cycle.
3. Response backpressure: resp_ready=0 for 20 cycles after resp_valid, with port 2 requesting. Expect resp_* stable, req_ready=0, no cls_input_is_valid until the handshake; then port 2 is granted the next cycle.
4. Busy classifier: cls_ready_to_process=0 held in IDLE with req_valid=0100 → no grant. Ready rises → grant port 2 that cycle.
5. Reset mid-WAIT: assert reset 3 cycles after ISSUE. Expect:
   - all outputs 0 and rr_ptr=0 immediately, asynchronously;
   - after release, req_valid=1010 grants port 1 first.
6. Saturation with LAT_W=4 and a 40-cycle classifier busy time → resp_cycles=15. With CLASSIFIER_ARB_STATS_EN, stat_max_cycles=15, and stat_clear zeroes it.
